// File: rtl/pipe_scheduler.sv
// Issue/stall scheduler for the 4-stage 8-bit pipeline: register scoreboard,
// run/halt/step sequencer, and hazard-stall / issue performance counters.
module pipe_scheduler #(
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       id_valid,
  input  logic [1:0] id_opcode,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic [2:0] id_rd,
  input  logic       br_taken,
  input  logic       wb_regwrite,
  input  logic [2:0] wb_rd,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       busy,
  output logic [1:0] state,
  output logic [7:0] stall_cnt,
  output logic [7:0] issue_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    DRAIN = 2'b11
  } schedState_t;

  schedState_t stateQ, stateNext;
  logic [7:0]  sbQ, sbNext, sbView, wbClrMask, rdSetMask;
  logic [7:0]  stallCntQ, issueCntQ;
  logic        hazard, issue, issueWindow, isBranch, stallCycle, clearCnt;

  // Handshake: id_valid marks IF/ID as holding an instruction; it is consumed
  // (issued) in any cycle where issue=1, otherwise it is held (ifid_we=0).
  assign isBranch    = (id_opcode == 2'b11);
  assign issueWindow = ~reset & ((stateQ == RUN) | (stateQ == STEP));

  always_comb begin
    wbClrMask = '0;
    if (wb_regwrite) wbClrMask[wb_rd] = 1'b1;
  end

  // With bypass, a register being written back this cycle is already readable.
  assign sbView     = WB_BYPASS ? (sbQ & ~wbClrMask) : sbQ;
  assign hazard     = id_valid & (sbView[id_rs] | sbView[id_rt]);
  assign issue      = issueWindow & id_valid & ~hazard;
  assign stallCycle = issueWindow & hazard;

  always_comb begin
    rdSetMask = '0;
    if (issue && !isBranch) rdSetMask[id_rd] = 1'b1;
  end

  // Set after clear so an issuing producer wins over a same-register writeback.
  assign sbNext = (sbQ & ~wbClrMask) | rdSetMask;

  always_comb begin
    stateNext = stateQ;
    clearCnt  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (!halt_req) begin
          if (run_req) begin
            stateNext = RUN;
            clearCnt  = 1'b1;
          end else if (step_req) begin
            stateNext = STEP;
          end
        end
      end
      RUN:     if (halt_req) stateNext = DRAIN;
      STEP:    if (halt_req || issue) stateNext = DRAIN;
      DRAIN:   if (sbNext == 8'h00) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    if (issueWindow) begin
      if (hazard) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
      end else if (!id_valid) begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end else begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = isBranch & br_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      sbQ       <= '0;
      stallCntQ <= '0;
      issueCntQ <= '0;
    end else begin
      stateQ <= stateNext;
      sbQ    <= sbNext;
      if (clearCnt) begin
        stallCntQ <= '0;
        issueCntQ <= '0;
      end else begin
        if (stallCycle && (stallCntQ != 8'hFF)) stallCntQ <= stallCntQ + 8'd1;
        if (issue) issueCntQ <= issueCntQ + 8'd1;
      end
    end
  end

  assign state     = stateQ;
  assign busy      = ~reset & (stateQ != IDLE);
  assign stall_cnt = stallCntQ;
  assign issue_cnt = issueCntQ;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: one instance without and one with
// writeback bypass, driven by the same input sequence.
module tb_pipe_scheduler;

  logic       clk;
  logic       reset;
  logic       run_req, halt_req, step_req;
  logic       id_valid;
  logic [1:0] id_opcode;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       br_taken;
  logic       wb_regwrite;
  logic [2:0] wb_rd;

  logic       pc_we, ifid_we, ifid_flush, idex_bubble, busy;
  logic [1:0] state;
  logic [7:0] stall_cnt, issue_cnt;

  logic       bpPcWe, bpIfidWe, bpIfidFlush, bpIdexBubble, bpBusy;
  logic [1:0] bpState;
  logic [7:0] bpStallCnt, bpIssueCnt;

  int checks = 0;
  int failures = 0;

  pipe_scheduler #(.WB_BYPASS(1'b0)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .busy(busy), .state(state), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  pipe_scheduler #(.WB_BYPASS(1'b1)) dutBp (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .pc_we(bpPcWe),
    .ifid_we(bpIfidWe), .ifid_flush(bpIfidFlush), .idex_bubble(bpIdexBubble),
    .busy(bpBusy), .state(bpState), .stall_cnt(bpStallCnt), .issue_cnt(bpIssueCnt)
  );

  // Clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setId(input logic v, input logic [1:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd, input logic taken);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    br_taken  = taken;
  endtask

  task automatic setWb(input logic we, input logic [2:0] rd);
    wb_regwrite = we;
    wb_rd       = rd;
  endtask

  task automatic clearInputs();
    run_req  = 1'b0;
    halt_req = 1'b0;
    step_req = 1'b0;
    setId(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
    setWb(1'b0, 3'd0);
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic goRun();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    #1;

    // Reset: held two cycles, then idle with no requests.
    chk("rst_pc_we", pc_we, 0);
    chk("rst_bubble", idex_bubble, 1);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("idle_state", state, 2'b00);
      chk("idle_pc_we", pc_we, 0);
      chk("idle_ifid_we", ifid_we, 0);
      chk("idle_flush", ifid_flush, 0);
      chk("idle_bubble", idex_bubble, 1);
      chk("idle_stall_cnt", stall_cnt, 0);
      chk("idle_issue_cnt", issue_cnt, 0);
      tick();
    end

    // RAW stall: producer rd=3 issues in N, consumer reads r3.
    doReset();
    goRun();
    setId(1'b1, 2'b00, 3'd0, 3'd1, 3'd3, 1'b0);
    settle();
    chk("raw_state_run", state, 2'b01);
    chk("raw_prod_issue", idex_bubble, 0);
    chk("raw_prod_pc_we", pc_we, 1);
    tick();
    setId(1'b1, 2'b01, 3'd3, 3'd0, 3'd6, 1'b0);
    settle();
    chk("raw_n1_pc_we", pc_we, 0);
    chk("raw_n1_ifid_we", ifid_we, 0);
    chk("raw_n1_bubble", idex_bubble, 1);
    chk("raw_bp_n1_pc_we", bpPcWe, 0);
    tick();
    setWb(1'b1, 3'd3);
    settle();
    chk("raw_n2_pc_we", pc_we, 0);
    chk("raw_n2_stall_cnt", stall_cnt, 1);
    chk("raw_bp_n2_pc_we", bpPcWe, 1);
    chk("raw_bp_n2_bubble", bpIdexBubble, 0);
    tick();
    setWb(1'b0, 3'd0);
    settle();
    chk("raw_n3_pc_we", pc_we, 1);
    chk("raw_n3_bubble", idex_bubble, 0);
    chk("raw_n3_stall_cnt", stall_cnt, 2);
    chk("raw_n3_issue_cnt", issue_cnt, 1);
    chk("raw_bp_n3_stall_cnt", bpStallCnt, 1);
    tick();
    setId(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    chk("raw_n4_issue_cnt", issue_cnt, 2);
    chk("raw_n4_stall_cnt", stall_cnt, 2);
    chk("noval_pc_we", pc_we, 1);
    chk("noval_ifid_we", ifid_we, 1);
    chk("noval_bubble", idex_bubble, 1);
    tick();

    // Taken branch, then an op reading the branch's rd field, then a branch stalled on rt.
    doReset();
    goRun();
    setId(1'b1, 2'b11, 3'd1, 3'd2, 3'd7, 1'b1);
    settle();
    chk("br_flush", ifid_flush, 1);
    chk("br_pc_we", pc_we, 1);
    chk("br_bubble", idex_bubble, 0);
    tick();
    setId(1'b1, 2'b00, 3'd7, 3'd7, 3'd0, 1'b0);
    settle();
    chk("br_issue_cnt", issue_cnt, 1);
    chk("br_no_sb7_flush", ifid_flush, 0);
    chk("br_no_sb7_bubble", idex_bubble, 0);
    tick();
    setId(1'b1, 2'b11, 3'd1, 3'd0, 3'd0, 1'b1);
    settle();
    chk("br_rt_haz_pc_we", pc_we, 0);
    chk("br_rt_haz_flush", ifid_flush, 0);
    chk("br_rt_haz_bubble", idex_bubble, 1);
    tick();

    // Single step from IDLE.
    doReset();
    step_req = 1'b1;
    settle();
    chk("step_idle_pc_we", pc_we, 0);
    tick();
    step_req = 1'b0;
    setId(1'b1, 2'b00, 3'd1, 3'd2, 3'd4, 1'b0);
    settle();
    chk("step_state", state, 2'b10);
    chk("step_busy", busy, 1);
    chk("step_issue", idex_bubble, 0);
    chk("step_pc_we", pc_we, 1);
    tick();
    setId(1'b1, 2'b00, 3'd0, 3'd0, 3'd1, 1'b0);
    settle();
    chk("step_drain_state", state, 2'b11);
    chk("step_drain_bubble", idex_bubble, 1);
    chk("step_drain_pc_we", pc_we, 0);
    chk("step_drain_ifid_we", ifid_we, 0);
    chk("step_issue_cnt", issue_cnt, 1);
    tick();
    setWb(1'b1, 3'd4);
    settle();
    chk("step_drain2_state", state, 2'b11);
    tick();
    setWb(1'b0, 3'd0);
    settle();
    chk("step_done_state", state, 2'b00);
    chk("step_done_busy", busy, 0);
    chk("step_done_issue_cnt", issue_cnt, 1);
    tick();

    // Halt with an in-flight write to r5; run_req in DRAIN is ignored.
    doReset();
    goRun();
    setId(1'b1, 2'b00, 3'd0, 3'd1, 3'd5, 1'b0);
    settle();
    chk("halt_issue", idex_bubble, 0);
    tick();
    setId(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
    halt_req = 1'b1;
    settle();
    chk("halt_req_state", state, 2'b01);
    tick();
    halt_req = 1'b0;
    run_req  = 1'b1;
    settle();
    chk("halt_drain_state", state, 2'b11);
    chk("halt_drain_pc_we", pc_we, 0);
    chk("halt_drain_bubble", idex_bubble, 1);
    tick();
    run_req = 1'b0;
    setWb(1'b1, 3'd5);
    settle();
    chk("halt_drain2_state", state, 2'b11);
    tick();
    setWb(1'b0, 3'd0);
    settle();
    chk("halt_idle_state", state, 2'b00);
    tick();

    // Set/clear collision on r4, then a long stall to saturate stall_cnt.
    doReset();
    goRun();
    setId(1'b1, 2'b00, 3'd0, 3'd1, 3'd4, 1'b0);
    setWb(1'b1, 3'd4);
    settle();
    chk("coll_issue", idex_bubble, 0);
    tick();
    setWb(1'b0, 3'd0);
    setId(1'b1, 2'b00, 3'd4, 3'd0, 3'd2, 1'b0);
    settle();
    chk("coll_sb4_pc_we", pc_we, 0);
    chk("coll_sb4_bubble", idex_bubble, 1);
    chk("coll_stall_cnt0", stall_cnt, 0);
    for (int i = 0; i < 254; i++) tick();
    settle();
    chk("sat_stall_254", stall_cnt, 254);
    tick();
    settle();
    chk("sat_stall_255", stall_cnt, 255);
    for (int i = 0; i < 45; i++) tick();
    settle();
    chk("sat_stall_hold", stall_cnt, 255);
    chk("sat_issue_cnt", issue_cnt, 1);
    setId(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
    setWb(1'b1, 3'd4);
    halt_req = 1'b1;
    tick();
    setWb(1'b0, 3'd0);
    halt_req = 1'b0;
    settle();
    chk("sat_drain_state", state, 2'b11);
    tick();
    settle();
    chk("sat_idle_state", state, 2'b00);
    chk("sat_idle_stall_cnt", stall_cnt, 255);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    settle();
    chk("clr_state", state, 2'b01);
    chk("clr_stall_cnt", stall_cnt, 0);
    chk("clr_issue_cnt", issue_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
